// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store over valid/ready,
// performed on an internal word array and answered after a fixed latency.
module dmem_responder #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned LATENCY    = 2,
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic                    req_wen,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wmask,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err
);

   localparam int unsigned MASK_W = DATA_WIDTH / 8;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LIMIT = BASE + ADDR_WIDTH'(DEPTH * 8);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, stateNext;

   logic [3:0]            cnt;
   logic [ADDR_WIDTH-1:0] addrQ;
   logic                  wenQ;
   logic [DATA_WIDTH-1:0] wdataQ;
   logic [MASK_W-1:0]     wmaskQ;

   logic                  accept;
   logic                  doAccess;
   logic                  inRange;
   logic                  accWen;
   logic [ADDR_WIDTH-1:0] accAddr;
   logic [ADDR_WIDTH-1:0] offset;
   logic [DATA_WIDTH-1:0] accWdata;
   logic [MASK_W-1:0]     accWmask;
   logic [IDX_W-1:0]      idx;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   // Gating with rst keeps a single-cycle access from firing while reset is held.
   assign accept    = req_ready && req_valid && rst;

   // Access operands come straight from the request when LATENCY is 1, else from the latch.
   always_comb begin
      accAddr  = addrQ;
      accWen   = wenQ;
      accWdata = wdataQ;
      accWmask = wmaskQ;
      if (state == IDLE) begin
         accAddr  = req_addr;
         accWen   = req_wen;
         accWdata = req_wdata;
         accWmask = req_wmask;
      end
      offset  = accAddr - BASE;
      idx     = IDX_W'(offset >> 3);
      inRange = (accAddr >= BASE) && (accAddr < LIMIT);
      if (LATENCY == 1) begin
         doAccess = accept;
      end else begin
         doAccess = (state == BUSY) && (cnt == 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = (LATENCY == 1) ? RESP : BUSY;
         BUSY:    if (cnt == 4'd1) stateNext = RESP;
         RESP:    if (rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Request latch, latency counter and response registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= 4'd0;
         addrQ     <= '0;
         wenQ      <= 1'b0;
         wdataQ    <= '0;
         wmaskQ    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            addrQ  <= req_addr;
            wenQ   <= req_wen;
            wdataQ <= req_wdata;
            wmaskQ <= req_wmask;
            cnt    <= CNT_LOAD;
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
         if (doAccess) begin
            if (!inRange) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b1;
            end else if (accWen) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end else begin
               rsp_rdata <= mem[idx];
               rsp_err   <= 1'b0;
            end
         end
      end
   end

   // Storage array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (doAccess && inRange && accWen) begin
         for (int i = 0; i < int'(MASK_W); i++) begin
            if (accWmask[i]) mem[idx][8*i +: 8] <= accWdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances at LATENCY 2, 1, 7 and 4.
module tb_dmem_responder;

   logic             clk;
   logic [3:0]       rst;
   logic [3:0]       reqValid;
   logic [3:0]       reqReady;
   logic [3:0]       reqWen;
   logic [3:0]       rspValid;
   logic [3:0]       rspReady;
   logic [3:0]       rspErr;
   logic [3:0][63:0] reqAddr;
   logic [3:0][63:0] reqWdata;
   logic [3:0][63:0] rspRdata;
   logic [3:0][7:0]  reqWmask;

   int nChecks;
   int nFails;

   for (genvar g = 0; g < 4; g++) begin : gDut
      dmem_responder #(
         .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 7 : 4)
      ) uDut (
         .clk       (clk),
         .rst       (rst[g]),
         .req_valid (reqValid[g]),
         .req_ready (reqReady[g]),
         .req_addr  (reqAddr[g]),
         .req_wen   (reqWen[g]),
         .req_wdata (reqWdata[g]),
         .req_wmask (reqWmask[g]),
         .rsp_valid (rspValid[g]),
         .rsp_ready (rspReady[g]),
         .rsp_rdata (rspRdata[g]),
         .rsp_err   (rspErr[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request from a negedge with rsp_ready held high; returns after the handshake.
   task automatic doTxn(input int d, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] mask,
                        output int lat, output logic [63:0] rdata, output logic err,
                        output logic readyLow);
      reqWen[d]   = wen;
      reqAddr[d]  = addr;
      reqWdata[d] = wdata;
      reqWmask[d] = mask;
      reqValid[d] = 1'b1;
      readyLow    = 1'b1;
      @(negedge clk);
      reqValid[d] = 1'b0;
      lat = 1;
      while (!rspValid[d] && lat < 40) begin
         if (reqReady[d]) readyLow = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (reqReady[d]) readyLow = 1'b0;
      rdata = rspRdata[d];
      err   = rspErr[d];
      if (!rspValid[d]) lat = -1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst      = 4'b0000;
      reqValid = 4'b0000;
      reqWen   = 4'b0000;
      rspReady = 4'b1111;
      reqAddr  = '0;
      reqWdata = '0;
      reqWmask = '0;
      reqValid[1] = 1'b1;
      reqWen[1]   = 1'b1;
      reqAddr[1]  = 64'h8000_0000;
      reqWmask[1] = 8'hFF;
      repeat (3) @(negedge clk);
      nChecks++;
      if (reqReady !== 4'b1111) begin
         nFails++; $display("FAIL reset_req_ready: got %b expected %b", reqReady, 4'b1111);
      end
      nChecks++;
      if (rspValid !== 4'b0000) begin
         nFails++; $display("FAIL reset_rsp_valid: got %b expected %b", rspValid, 4'b0000);
      end
      nChecks++;
      if (rspRdata[0] !== 64'h0) begin
         nFails++; $display("FAIL reset_rdata: got %h expected %h", rspRdata[0], 64'h0);
      end
      nChecks++;
      if (rspErr[0] !== 1'b0) begin
         nFails++; $display("FAIL reset_err: got %b expected %b", rspErr[0], 1'b0);
      end
      reqValid = 4'b0000;
      rst      = 4'b1111;
      @(negedge clk);
      nChecks++;
      if (rspValid[1] !== 1'b0) begin
         nFails++; $display("FAIL reset_no_accept: got %b expected %b", rspValid[1], 1'b0);
      end
   endtask

   task automatic test_store_load();
      int lat; logic [63:0] rd; logic er; logic rl;
      doTxn(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, lat, rd, er, rl);
      nChecks++;
      if (lat !== 2) begin nFails++; $display("FAIL store_lat: got %0d expected %0d", lat, 2); end
      nChecks++;
      if (rd !== 64'h0 || er !== 1'b0) begin
         nFails++; $display("FAIL store_rsp: got rdata %h err %b expected rdata 0 err 0", rd, er);
      end
      doTxn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'h1122_3344_5566_7788 || er !== 1'b0) begin
         nFails++; $display("FAIL load_data: got %h err %b expected %h err 0", rd, er, 64'h1122_3344_5566_7788);
      end
      nChecks++;
      if (lat !== 2) begin nFails++; $display("FAIL load_lat: got %0d expected %0d", lat, 2); end
   endtask

   task automatic test_byte_mask();
      int lat; logic [63:0] rd; logic er; logic rl;
      doTxn(0, 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, lat, rd, er, rl);
      doTxn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'h1122_3344_AAAA_AAAA) begin
         nFails++; $display("FAIL mask_merge: got %h expected %h", rd, 64'h1122_3344_AAAA_AAAA);
      end
      // Low address bits are ignored, so this hits the same word.
      doTxn(0, 1'b0, 64'h8000_0017, 64'h0, 8'h00, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'h1122_3344_AAAA_AAAA || er !== 1'b0) begin
         nFails++; $display("FAIL unaligned_load: got %h err %b expected %h err 0", rd, er, 64'h1122_3344_AAAA_AAAA);
      end
   endtask

   task automatic test_latency_sweep();
      int lat; logic [63:0] rd; logic er; logic rl;
      for (int i = 0; i < 3; i++) begin
         int d;
         int expLat;
         logic [63:0] wd;
         d      = (i == 0) ? 1 : (i == 1) ? 0 : 2;
         expLat = (i == 0) ? 1 : (i == 1) ? 2 : 7;
         wd     = 64'hC0DE_0000_0000_0000 | 64'(i);
         doTxn(d, 1'b1, 64'h8000_0100, wd, 8'hFF, lat, rd, er, rl);
         nChecks++;
         if (lat !== expLat) begin
            nFails++; $display("FAIL sweep_lat[%0d]: got %0d expected %0d", i, lat, expLat);
         end
         nChecks++;
         if (rl !== 1'b1) begin
            nFails++; $display("FAIL sweep_ready_low[%0d]: got %b expected %b", i, rl, 1'b1);
         end
         nChecks++;
         if (reqReady[d] !== 1'b1 || rspValid[d] !== 1'b0) begin
            nFails++; $display("FAIL sweep_idle[%0d]: got ready %b valid %b expected 1 0", i, reqReady[d], rspValid[d]);
         end
         doTxn(d, 1'b0, 64'h8000_0100, 64'h0, 8'h00, lat, rd, er, rl);
         nChecks++;
         if (rd !== wd || lat !== expLat) begin
            nFails++; $display("FAIL sweep_load[%0d]: got %h lat %0d expected %h lat %0d", i, rd, lat, wd, expLat);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [63:0] rd; logic er; logic rl;
      int n;
      doTxn(0, 1'b1, 64'h8000_0020, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, lat, rd, er, rl);
      rspReady[0] = 1'b0;
      reqWen[0]   = 1'b0;
      reqAddr[0]  = 64'h8000_0020;
      reqValid[0] = 1'b1;
      @(negedge clk);
      reqValid[0] = 1'b0;
      n = 0;
      while (!rspValid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      nChecks++;
      if (rspValid[0] !== 1'b1) begin
         nFails++; $display("FAIL bp_timeout: got rsp_valid %b expected %b", rspValid[0], 1'b1);
      end
      for (int i = 0; i < 5; i++) begin
         nChecks++;
         if (rspValid[0] !== 1'b1 || rspErr[0] !== 1'b0 || reqReady[0] !== 1'b0) begin
            nFails++; $display("FAIL bp_ctrl[%0d]: got valid %b err %b ready %b expected 1 0 0", i, rspValid[0], rspErr[0], reqReady[0]);
         end
         nChecks++;
         if (rspRdata[0] !== 64'hDEAD_BEEF_CAFE_F00D) begin
            nFails++; $display("FAIL bp_data[%0d]: got %h expected %h", i, rspRdata[0], 64'hDEAD_BEEF_CAFE_F00D);
         end
         if (i == 1) begin
            reqWen[0]   = 1'b1;
            reqWdata[0] = 64'h0;
            reqWmask[0] = 8'hFF;
            reqValid[0] = 1'b1;
         end
         if (i == 3) reqValid[0] = 1'b0;
         @(negedge clk);
      end
      reqValid[0] = 1'b0;
      rspReady[0] = 1'b1;
      @(negedge clk);
      nChecks++;
      if (reqReady[0] !== 1'b1 || rspValid[0] !== 1'b0) begin
         nFails++; $display("FAIL bp_release: got ready %b valid %b expected 1 0", reqReady[0], rspValid[0]);
      end
      doTxn(0, 1'b0, 64'h8000_0020, 64'h0, 8'h00, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'hDEAD_BEEF_CAFE_F00D) begin
         nFails++; $display("FAIL bp_no_store: got %h expected %h", rd, 64'hDEAD_BEEF_CAFE_F00D);
      end
   endtask

   task automatic test_out_of_range();
      int lat; logic [63:0] rd; logic er; logic rl;
      doTxn(0, 1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rd, er, rl);
      doTxn(0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'h0 || er !== 1'b1) begin
         nFails++; $display("FAIL oor_load: got %h err %b expected 0 err 1", rd, er);
      end
      doTxn(0, 1'b1, 64'h8000_0800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'h0 || er !== 1'b1) begin
         nFails++; $display("FAIL oor_store: got %h err %b expected 0 err 1", rd, er);
      end
      doTxn(0, 1'b1, 64'h8000_07F8, 64'h5555_6666_7777_8888, 8'hFF, lat, rd, er, rl);
      doTxn(0, 1'b0, 64'h8000_07F8, 64'h0, 8'h00, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'h5555_6666_7777_8888 || er !== 1'b0) begin
         nFails++; $display("FAIL last_word: got %h err %b expected %h err 0", rd, er, 64'h5555_6666_7777_8888);
      end
      doTxn(0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'h0123_4567_89AB_CDEF || er !== 1'b0) begin
         nFails++; $display("FAIL word0_intact: got %h err %b expected %h err 0", rd, er, 64'h0123_4567_89AB_CDEF);
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [63:0] rd; logic er; logic rl;
      doTxn(3, 1'b1, 64'h8000_0040, 64'h0A0B_0C0D_0E0F_1011, 8'hFF, lat, rd, er, rl);
      nChecks++;
      if (lat !== 4) begin nFails++; $display("FAIL rm_lat: got %0d expected %0d", lat, 4); end
      reqWen[3]   = 1'b1;
      reqAddr[3]  = 64'h8000_0040;
      reqWdata[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      reqWmask[3] = 8'hFF;
      reqValid[3] = 1'b1;
      @(negedge clk);
      reqValid[3] = 1'b0;
      nChecks++;
      if (reqReady[3] !== 1'b0) begin
         nFails++; $display("FAIL rm_accepted: got ready %b expected %b", reqReady[3], 1'b0);
      end
      rst[3] = 1'b0;
      #1;
      nChecks++;
      if (reqReady[3] !== 1'b1 || rspValid[3] !== 1'b0) begin
         nFails++; $display("FAIL rm_async: got ready %b valid %b expected 1 0", reqReady[3], rspValid[3]);
      end
      @(negedge clk);
      nChecks++;
      if (reqReady[3] !== 1'b1 || rspValid[3] !== 1'b0) begin
         nFails++; $display("FAIL rm_in_reset: got ready %b valid %b expected 1 0", reqReady[3], rspValid[3]);
      end
      rst[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nChecks++;
         if (rspValid[3] !== 1'b0) begin
            nFails++; $display("FAIL rm_no_rsp[%0d]: got %b expected %b", i, rspValid[3], 1'b0);
         end
      end
      doTxn(3, 1'b0, 64'h8000_0040, 64'h0, 8'h00, lat, rd, er, rl);
      nChecks++;
      if (rd !== 64'h0A0B_0C0D_0E0F_1011 || lat !== 4) begin
         nFails++; $display("FAIL rm_old_data: got %h lat %0d expected %h lat 4", rd, lat, 64'h0A0B_0C0D_0E0F_1011);
      end
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      test_reset();
      test_store_load();
      test_byte_mask();
      test_latency_sweep();
      test_backpressure();
      test_out_of_range();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
